// File: rtl/pmd901_spi_pkg.sv
// Shared types for the PMD901 SPI master: data width and FSM state encoding.
package pmd901_spi_pkg;

    localparam int SPEED_W   = 16;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } pmd901_spi_state_e;

endpackage

// File: rtl/pmd901_sync2.sv
// Two-flop synchroniser for asynchronous PMD901 status pins; both flops clear on reset.
module pmd901_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pmd901_spi_master.sv
// PMD901 driver: serialises 16-bit speed commands as SPI frames and owns the park/bend pins.
// Optional feature macro PMD901_FAULT_ABORT_EN: a synced fault aborts the in-flight frame.
module pmd901_spi_master
    import pmd901_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CSN_GAP = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [SPEED_W-1:0] cmd_speed,
    input  logic               park_req,
    input  logic               bend_req,
    output logic               spi_clk,
    output logic               spi_csn,
    output logic               spi_mosi,
    output logic               pmd_park,
    output logic               pmd_bend,
    input  logic               pmd_fault,
    input  logic               pmd_fan,
    input  logic               pmd_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_abort,
    output logic               fault_sticky,
    output logic               fan_s,
    output logic               dev_ready_s
);

    localparam int HCNT_W = $clog2(CLK_DIV + 1);
    localparam int GCNT_W = $clog2(CSN_GAP + 1);
    localparam logic [HCNT_W-1:0]    HCNT_LAST = HCNT_W'(CLK_DIV - 1);
    localparam logic [GCNT_W-1:0]    GCNT_LAST = GCNT_W'(CSN_GAP - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(SPEED_W - 1);

    pmd901_spi_state_e    state_q, state_d;
    logic [HCNT_W-1:0]    hcnt_q, hcnt_d;
    logic [GCNT_W-1:0]    gcnt_q, gcnt_d;
    logic [BIT_CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [SPEED_W-1:0]   shreg_q, shreg_d;
    logic                 sclk_d, csn_d, mosi_d, park_d, bend_d, done_d, abort_d;
    logic                 fault_s;

    pmd901_sync2 u_sync_fault (.clk(clk), .rst(rst), .d(pmd_fault), .q(fault_s));
    pmd901_sync2 u_sync_fan   (.clk(clk), .rst(rst), .d(pmd_fan),   .q(fan_s));
    pmd901_sync2 u_sync_ready (.clk(clk), .rst(rst), .d(pmd_ready), .q(dev_ready_s));

    assign busy      = (state_q != IDLE);
    assign cmd_ready = (state_q == IDLE) && pmd_park && dev_ready_s && !fault_s;

    // All pin outputs are registered so the device sees glitch-free edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hcnt_q       <= '0;
            gcnt_q       <= '0;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            spi_clk      <= 1'b0;
            spi_csn      <= 1'b1;
            spi_mosi     <= 1'b0;
            pmd_park     <= 1'b0;
            pmd_bend     <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
            fault_sticky <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            gcnt_q       <= gcnt_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            spi_clk      <= sclk_d;
            spi_csn      <= csn_d;
            spi_mosi     <= mosi_d;
            pmd_park     <= park_d;
            pmd_bend     <= bend_d;
            frame_done   <= done_d;
            frame_abort  <= abort_d;
            fault_sticky <= fault_sticky | fault_s;
        end
    end

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        gcnt_d   = gcnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        sclk_d   = spi_clk;
        csn_d    = spi_csn;
        mosi_d   = spi_mosi;
        park_d   = pmd_park;
        bend_d   = pmd_bend;
        done_d   = 1'b0;
        abort_d  = 1'b0;

        case (state_q)
            // Pin requests are only honoured here, so bend never moves under a low csn.
            IDLE: begin
                park_d = park_req;
                bend_d = bend_req;
                if (cmd_valid && cmd_ready) begin
                    state_d = SETUP;
                    shreg_d = cmd_speed;
                    hcnt_d  = '0;
                    csn_d   = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = cmd_speed[SPEED_W-1];
                end
            end
            SETUP: begin
                if (hcnt_q == HCNT_LAST) begin
                    state_d  = SHIFT;
                    hcnt_d   = '0;
                    bitcnt_d = '0;
                    sclk_d   = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            // Data moves on the falling edge so mosi is settled for the next rise.
            SHIFT: begin
                if (hcnt_q == HCNT_LAST) begin
                    hcnt_d = '0;
                    if (spi_clk) begin
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[SPEED_W-2:0], 1'b0};
                        mosi_d  = shreg_q[SPEED_W-2];
                    end else if (bitcnt_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        bitcnt_d = bitcnt_q + BIT_CNT_W'(1);
                        sclk_d   = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            HOLD: begin
                if (hcnt_q == HCNT_LAST) begin
                    state_d = GAP;
                    gcnt_d  = '0;
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            GAP: begin
                if (gcnt_q == GCNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + GCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PMD901_FAULT_ABORT_EN
        if (fault_s && (state_q == SETUP || state_q == SHIFT || state_q == HOLD)) begin
            state_d = GAP;
            gcnt_d  = '0;
            hcnt_d  = '0;
            csn_d   = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            done_d  = 1'b0;
            abort_d = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_pmd901_spi_master.sv
// Self-checking bench for pmd901_spi_master: a pin-level monitor rebuilds each SPI frame and is compared to the commanded word.
module tb_pmd901_spi_master;

    localparam int CD      = 2;
    localparam int GAPC    = 8;
    localparam int LOWC    = 34 * CD;
    localparam int WAITMAX = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_speed = 16'h0000;
    logic        park_req = 1'b0;
    logic        bend_req = 1'b0;
    logic        pmd_fault = 1'b0;
    logic        pmd_fan = 1'b0;
    logic        pmd_ready = 1'b0;
    logic        cmd_ready, spi_clk, spi_csn, spi_mosi, pmd_park, pmd_bend;
    logic        busy, frame_done, frame_abort, fault_sticky, fan_s, dev_ready_s;

    pmd901_spi_master #(.CLK_DIV(CD), .CSN_GAP(GAPC)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_speed(cmd_speed), .park_req(park_req), .bend_req(bend_req),
        .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .pmd_park(pmd_park), .pmd_bend(pmd_bend), .pmd_fault(pmd_fault),
        .pmd_fan(pmd_fan), .pmd_ready(pmd_ready), .busy(busy),
        .frame_done(frame_done), .frame_abort(frame_abort),
        .fault_sticky(fault_sticky), .fan_s(fan_s), .dev_ready_s(dev_ready_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin-level monitor state, written only by the monitor process.
    logic        prevCsn = 1'b1, prevSclk = 1'b0, prevBend = 1'b0, lastRiseDone = 1'b0;
    logic [15:0] curBits = '0, lastBits = '0;
    int curRises = 0, lastRises = 0, curLow = 0, lastLow = 0;
    int frames = 0, falls = 0, highRun = 0, lastGap = 0;
    int doneCnt = 0, abortCnt = 0, bendBad = 0, clkBad = 0;

    int nChecks = 0;
    int nFail = 0;
    int hsCyc = 0;
    logic expBend = 1'b0;
    logic [15:0] modelQ[$];

    typedef struct {
        logic [15:0] speed;
        logic        bend;
        logic [15:0] expWord;
    } vec_t;
    vec_t vecs[5];

    // Rebuild frames the way the device's agent would: mosi sampled on every spi_clk rise under csn low.
    always @(negedge clk) begin
        if (rst) begin
            prevCsn  = 1'b1;
            prevSclk = 1'b0;
            prevBend = pmd_bend;
            highRun  = 0;
        end else begin
            if (!spi_csn) begin
                if (prevCsn) begin
                    curBits  = '0;
                    curRises = 0;
                    curLow   = 0;
                    lastGap  = highRun;
                    falls++;
                end
                curLow++;
                if (spi_clk && !prevSclk) begin
                    curBits = {curBits[14:0], spi_mosi};
                    curRises++;
                end
            end else begin
                if (!prevCsn) begin
                    lastBits     = curBits;
                    lastRises    = curRises;
                    lastLow      = curLow;
                    lastRiseDone = frame_done;
                    highRun      = 0;
                    frames++;
                end
                highRun++;
                if (spi_clk) clkBad++;
            end
            if (pmd_bend != prevBend && !spi_csn) bendBad++;
            if (frame_done) doneCnt++;
            if (frame_abort) abortCnt++;
            prevCsn  = spi_csn;
            prevSclk = spi_clk;
            prevBend = pmd_bend;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] speed);
        int n;
        n = 0;
        cmd_speed = speed;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < WAITMAX) begin
            tick();
            n++;
        end
        checkOutput("handshake_wait", 32'(n < WAITMAX), 1);
        @(posedge clk);
        tick();
        hsCyc     = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic waitFrame(input int startFrames);
        int n;
        n = 0;
        while (frames == startFrames && n < WAITMAX) begin
            tick();
            n++;
        end
        checkOutput("frame_end_wait", 32'(n < WAITMAX), 1);
    endtask

    task automatic waitRises(input int r);
        int n;
        n = 0;
        while (curRises < r && n < WAITMAX) begin
            tick();
            n++;
        end
        checkOutput("rise_wait", 32'(n < WAITMAX), 1);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < WAITMAX) begin
            tick();
            n++;
        end
        checkOutput("idle_wait", 32'(n < WAITMAX), 1);
    endtask

    task automatic checkFrame(input logic [15:0] exp);
        checkOutput("frame_word", 32'(lastBits), 32'(exp));
        checkOutput("frame_rises", lastRises, 16);
        checkOutput("frame_csn_low", lastLow, LOWC);
        checkOutput("frame_done_at_csn_rise", 32'(lastRiseDone), 1);
    endtask

    initial begin
        int sDone, sAbort, sFalls, sFrames, h1, h2, n;
        logic [15:0] w;

        vecs[0] = '{16'h8001, 1'b1, 16'h8001};
        vecs[1] = '{16'h0001, 1'b0, 16'h0001};
        vecs[2] = '{16'hFFFF, 1'b1, 16'hFFFF};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000};
        vecs[4] = '{16'h5A5A, 1'b1, 16'h5A5A};

        $display("[TB] reset phase");
        pmd_fan   = 1'b1;
        pmd_ready = 1'b1;
        repeat (3) tick();
        checkOutput("rst_csn", 32'(spi_csn), 1);
        checkOutput("rst_sclk", 32'(spi_clk), 0);
        checkOutput("rst_mosi", 32'(spi_mosi), 0);
        checkOutput("rst_park", 32'(pmd_park), 0);
        checkOutput("rst_bend", 32'(pmd_bend), 0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(frame_done), 0);
        checkOutput("rst_abort", 32'(frame_abort), 0);
        checkOutput("rst_sticky", 32'(fault_sticky), 0);
        checkOutput("rst_fan_s", 32'(fan_s), 0);
        checkOutput("rst_ready_s", 32'(dev_ready_s), 0);

        rst = 1'b0;
        tick();
        checkOutput("sync_fan_1cyc", 32'(fan_s), 0);
        tick();
        checkOutput("sync_fan_2cyc", 32'(fan_s), 1);
        checkOutput("sync_ready_2cyc", 32'(dev_ready_s), 1);

        $display("[TB] park gating");
        sFalls    = falls;
        cmd_speed = 16'hA5C3;
        cmd_valid = 1'b1;
        repeat (10) tick();
        checkOutput("unparked_cmd_ready", 32'(cmd_ready), 0);
        checkOutput("unparked_no_csn", falls - sFalls, 0);
        park_req = 1'b1;
        tick();
        checkOutput("park_applied", 32'(pmd_park), 1);

        $display("[TB] first frame timing");
        sDone   = doneCnt;
        sFrames = frames;
        applyStimulus(16'hA5C3);
        checkOutput("first_csn_low", 32'(spi_csn), 0);
        checkOutput("first_mosi_bit15", 32'(spi_mosi), 1);
        checkOutput("first_sclk_low", 32'(spi_clk), 0);
        repeat (CD - 1) tick();
        checkOutput("setup_sclk_low", 32'(spi_clk), 0);
        tick();
        checkOutput("first_sclk_rise", 32'(spi_clk), 1);
        waitFrame(sFrames);
        checkFrame(16'hA5C3);
        checkOutput("first_done_once", doneCnt - sDone, 1);

        $display("[TB] table vectors with bend toggles");
        for (int i = 0; i < 5; i++) begin
            sFrames = frames;
            applyStimulus(vecs[i].speed);
            waitRises(5);
            bend_req = vecs[i].bend;
            tick();
            checkOutput("bend_mid_frame", 32'(pmd_bend), 32'(expBend));
            waitFrame(sFrames);
            checkFrame(vecs[i].expWord);
            checkOutput("bend_after_csn_rise", 32'(pmd_bend), 32'(expBend));
            waitIdle();
            tick();
            checkOutput("bend_in_idle", 32'(pmd_bend), 32'(vecs[i].bend));
            expBend = vecs[i].bend;
        end

        $display("[TB] back-to-back frames");
        sFrames = frames;
        applyStimulus(16'h8001);
        h1 = hsCyc;
        applyStimulus(16'h0001);
        h2 = hsCyc;
        checkOutput("b2b_spacing", 32'((h2 - h1) >= LOWC + GAPC), 1);
        checkOutput("b2b_first_word", 32'(lastBits), 32'h8001);
        waitFrame(sFrames + 1);
        checkFrame(16'h0001);
        checkOutput("b2b_csn_gap", 32'(lastGap >= GAPC), 1);

        $display("[TB] randomized frames");
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom_range(0, 65535));
            modelQ.push_back(w);
            repeat ($urandom_range(0, 5)) tick();
            sFrames = frames;
            applyStimulus(w);
            waitFrame(sFrames);
            checkFrame(modelQ.pop_front());
        end

        $display("[TB] fault during shift");
        waitIdle();
        sDone   = doneCnt;
        sAbort  = abortCnt;
        sFrames = frames;
        applyStimulus(16'h3C96);
        waitRises(8);
        pmd_fault = 1'b1;
        tick();
        tick();
        checkOutput("sticky_before_3cyc", 32'(fault_sticky), 0);
        tick();
        checkOutput("sticky_at_3cyc", 32'(fault_sticky), 1);
`ifdef PMD901_FAULT_ABORT_EN
        n = 3;
        while (!spi_csn && n < 10) begin
            tick();
            n++;
        end
        checkOutput("abort_csn_latency_ok", 32'(n <= 4), 1);
        checkOutput("abort_sclk", 32'(spi_clk), 0);
        checkOutput("abort_mosi", 32'(spi_mosi), 0);
        repeat (20) tick();
        checkOutput("abort_pulse_once", abortCnt - sAbort, 1);
        checkOutput("abort_no_done", doneCnt - sDone, 0);
`else
        waitFrame(sFrames);
        checkFrame(16'h3C96);
        repeat (20) tick();
        checkOutput("nofault_abort_done_once", doneCnt - sDone, 1);
        checkOutput("nofault_abort_zero", abortCnt - sAbort, 0);
`endif
        checkOutput("fault_busy_idle", 32'(busy), 0);
        checkOutput("fault_blocks_ready", 32'(cmd_ready), 0);
        pmd_fault = 1'b0;
        repeat (4) tick();
        checkOutput("ready_after_fault_clears", 32'(cmd_ready), 1);
        checkOutput("sticky_holds", 32'(fault_sticky), 1);

        $display("[TB] reset mid-frame");
        applyStimulus(16'hF00F);
        waitRises(4);
        sDone  = doneCnt;
        sAbort = abortCnt;
        rst = 1'b1;
        tick();
        checkOutput("midrst_csn", 32'(spi_csn), 1);
        checkOutput("midrst_sclk", 32'(spi_clk), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_mosi", 32'(spi_mosi), 0);
        checkOutput("midrst_sticky", 32'(fault_sticky), 0);
        checkOutput("midrst_park", 32'(pmd_park), 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("midrst_no_done", doneCnt - sDone, 0);
        checkOutput("midrst_no_abort", abortCnt - sAbort, 0);

        sFrames = frames;
        applyStimulus(16'h1357);
        waitFrame(sFrames);
        checkFrame(16'h1357);

        checkOutput("bend_never_under_csn", bendBad, 0);
        checkOutput("sclk_idle_low", clkBad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
